// File: rtl/core_wb_pkg.sv
// Shared constants for the writeback arbiter: load size encodings and
// fixed producer channel assignments.
package core_wb_pkg;

  // Load size encodings on i_ld_size; any value with bit 1 set is a word.
  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_WORD = 2'b10;

  // Producer channel indices.
  localparam int WB_SRC_LSU = 0;
  localparam int WB_SRC_MUL = 1;
  localparam int WB_SRC_FPU = 2;
  localparam int WB_SRC_CSR = 3;

endpackage

// File: rtl/core_wb_load_fmt.sv
// Combinational load formatter: selects a byte, half or word from the raw
// load data by address offset and sign- or zero-extends it to XLEN.
module core_wb_load_fmt
  import core_wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_data,
  input  logic [1:0]      i_size,
  input  logic            i_unsigned,
  input  logic [1:0]      i_offset,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection then extension; offset bit 0 is ignored for halves
  // because misaligned halves never reach this point.
  always_comb begin
    w_byte = i_data[8*i_offset +: 8];
    w_half = i_data[16*i_offset[1] +: 16];
    o_data = i_data;
    if ((i_size & LD_WORD) == 2'b00) begin
      if (i_size == LD_HALF) begin
        o_data = {{(XLEN-16){w_half[15] & ~i_unsigned}}, w_half};
      end else begin
        o_data = {{(XLEN-8){w_byte[7] & ~i_unsigned}}, w_byte};
      end
    end
  end

endmodule

// File: rtl/core_wb_arbiter.sv
// Writeback arbiter: one-entry holding buffer per producer channel, a
// round-robin grant of one buffered result per cycle, and a registered
// register-file write port. Channel 0 (load) is formatted at capture.
// Optional stall counter output enabled by macro CORE_WB_STALL_CNT_EN.
module core_wb_arbiter
  import core_wb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 4,
  parameter int RADDR_W = 5,
  localparam int SRC_W  = $clog2(NUM_SRC)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_SRC-1:0]         i_src_valid,
  output logic [NUM_SRC-1:0]         o_src_ready,
  input  logic [NUM_SRC*RADDR_W-1:0] i_src_rd,
  input  logic [NUM_SRC*XLEN-1:0]    i_src_data,
  input  logic [1:0]                 i_ld_size,
  input  logic                       i_ld_unsigned,
  input  logic [1:0]                 i_ld_offset,
  output logic                       o_wb_valid,
  output logic [RADDR_W-1:0]         o_wb_rd,
  output logic [XLEN-1:0]            o_wb_data,
  output logic [SRC_W-1:0]           o_wb_src
`ifdef CORE_WB_STALL_CNT_EN
  ,
  output logic [31:0]                o_stall_cnt
`endif
);

  logic [NUM_SRC-1:0]            r_full;
  logic [RADDR_W-1:0]            r_rd   [NUM_SRC];
  logic [XLEN-1:0]               r_data [NUM_SRC];
  logic [SRC_W-1:0]              r_ptr;
  logic                          r_wb_valid;
  logic [RADDR_W-1:0]            r_wb_rd;
  logic [XLEN-1:0]               r_wb_data;
  logic [SRC_W-1:0]              r_wb_src;

  logic                          w_gnt_any;
  logic [SRC_W-1:0]              w_gnt_idx;
  logic [NUM_SRC-1:0]            w_gnt_vec;
  logic [NUM_SRC-1:0]            w_accept;
  logic [XLEN-1:0]               w_ld_data;
  logic [NUM_SRC-1:0][XLEN-1:0]  w_cap_data;

  core_wb_load_fmt #(.XLEN(XLEN)) u_load_fmt (
    .i_data     (i_src_data[WB_SRC_LSU*XLEN +: XLEN]),
    .i_size     (i_ld_size),
    .i_unsigned (i_ld_unsigned),
    .i_offset   (i_ld_offset),
    .o_data     (w_ld_data)
  );

  // Capture data per channel: the load channel stores the formatted value.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cap
    if (gi == WB_SRC_LSU) begin : g_ld
      assign w_cap_data[gi] = w_ld_data;
    end else begin : g_raw
      assign w_cap_data[gi] = i_src_data[gi*XLEN +: XLEN];
    end
  end

  // Round-robin search: first full buffer at or after the pointer, wrapping.
  always_comb begin
    logic [SRC_W:0] w_cand;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_cand = {1'b0, r_ptr} + (SRC_W+1)'(i);
      if (w_cand >= (SRC_W+1)'(NUM_SRC)) begin
        w_cand = w_cand - (SRC_W+1)'(NUM_SRC);
      end
      if (!w_gnt_any && r_full[w_cand[SRC_W-1:0]]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand[SRC_W-1:0];
      end
    end
  end

  // One-hot grant vector derived from the winning index.
  always_comb begin
    w_gnt_vec = '0;
    if (w_gnt_any) begin
      w_gnt_vec[w_gnt_idx] = 1'b1;
    end
  end

  // A buffer being drained this cycle can be refilled in the same cycle.
  assign o_src_ready = ~r_full | w_gnt_vec;
  assign w_accept    = i_src_valid & o_src_ready;

  // Holding buffers: capture wins over drain so a refill keeps the slot full.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full <= '0;
      for (int k = 0; k < NUM_SRC; k++) begin
        r_rd[k]   <= '0;
        r_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (w_accept[k]) begin
          r_full[k] <= 1'b1;
          r_rd[k]   <= i_src_rd[k*RADDR_W +: RADDR_W];
          r_data[k] <= w_cap_data[k];
        end else if (w_gnt_vec[k]) begin
          r_full[k] <= 1'b0;
        end
      end
    end
  end

  // Registered write port and pointer advance; writes to x0 are dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_wb_src   <= '0;
      r_ptr      <= '0;
    end else if (w_gnt_any) begin
      r_wb_valid <= (r_rd[w_gnt_idx] != '0);
      r_wb_rd    <= r_rd[w_gnt_idx];
      r_wb_data  <= r_data[w_gnt_idx];
      r_wb_src   <= w_gnt_idx;
      r_ptr      <= (w_gnt_idx == SRC_W'(NUM_SRC-1)) ? '0 : w_gnt_idx + 1'b1;
    end else begin
      r_wb_valid <= 1'b0;
    end
  end

  assign o_wb_valid = r_wb_valid;
  assign o_wb_rd    = r_wb_rd;
  assign o_wb_data  = r_wb_data;
  assign o_wb_src   = r_wb_src;

`ifdef CORE_WB_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of cycles where some producer is held off.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if ((|(i_src_valid & ~o_src_ready)) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
